// File: rtl/alu_op_issuer.sv
// ALU operation issuer: latches operands, drives one-hot ALU control for
// SETTLE cycles, then captures the ALU result into HI/LO or Z.
module alu_op_issuer #(
  parameter int BITS      = 32,
  parameter int SIG_COUNT = 12,
  parameter int SETTLE    = 1
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [3:0]             opcode,
  input  logic [BITS-1:0]        a_in,
  input  logic [BITS-1:0]        b_in,
  output logic [SIG_COUNT-1:0]   ctrl_signal,
  output logic [BITS-1:0]        X,
  output logic [BITS-1:0]        Y,
  input  logic [2*BITS-1:0]      OpResult,
  output logic [BITS-1:0]        HI,
  output logic [BITS-1:0]        LO,
  output logic [BITS-1:0]        Z,
  output logic                   done,
  output logic                   illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [SIG_COUNT-1:0] ctrl_q, ctrl_d;
  logic [BITS-1:0]      x_q, x_d;
  logic [BITS-1:0]      y_q, y_d;
  logic [BITS-1:0]      hi_q, hi_d;
  logic [BITS-1:0]      lo_q, lo_d;
  logic [BITS-1:0]      z_q, z_d;
  logic                 wide_q, wide_d;
  logic                 done_q, done_d;
  logic                 ill_q, ill_d;
  logic                 legal;

  assign legal = {28'd0, opcode} < 32'(SIG_COUNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    x_d     = x_q;
    y_d     = y_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    z_d     = z_q;
    wide_d  = wide_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (legal) begin
            x_d     = a_in;
            y_d     = b_in;
            ctrl_d  = SIG_COUNT'(1) << opcode;
            cnt_d   = CNT_LOAD;
            wide_d  = (opcode == OP_MUL) || (opcode == OP_DIV);
            state_d = S_WAIT;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          // MUL/DIV produce a double-width result split across HI/LO
          if (wide_q) begin
            hi_d = OpResult[2*BITS-1:BITS];
            lo_d = OpResult[BITS-1:0];
          end else begin
            z_d = OpResult[BITS-1:0];
          end
          ctrl_d  = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      z_q     <= '0;
      wide_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      z_q     <= z_d;
      wide_q  <= wide_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  assign op_ready    = (state_q == S_IDLE);
  assign ctrl_signal = ctrl_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign Z           = z_q;
  assign done        = done_q;
  assign illegal     = ill_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: two instances (SETTLE=1 and SETTLE=3) checked
// against a cycle-level reference model of the issue/capture protocol.
module tb_alu_op_issuer;

  logic        clk;
  logic        clr      [2];
  logic        op_valid [2];
  logic        op_ready [2];
  logic [3:0]  opcode;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [63:0] opres;
  logic [11:0] ctrl     [2];
  logic [31:0] X        [2];
  logic [31:0] Y        [2];
  logic [31:0] HI       [2];
  logic [31:0] LO       [2];
  logic [31:0] Z        [2];
  logic        done     [2];
  logic        illegal  [2];

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;

  logic [31:0] exp_X  [2];
  logic [31:0] exp_Y  [2];
  logic [31:0] exp_HI [2];
  logic [31:0] exp_LO [2];
  logic [31:0] exp_Z  [2];

  alu_op_issuer #(.BITS(32), .SIG_COUNT(12), .SETTLE(1)) u_s1 (
    .clk(clk), .clr(clr[0]), .op_valid(op_valid[0]),
    .op_ready(op_ready[0]), .opcode(opcode), .a_in(a_in),
    .b_in(b_in), .ctrl_signal(ctrl[0]), .X(X[0]), .Y(Y[0]),
    .OpResult(opres), .HI(HI[0]), .LO(LO[0]), .Z(Z[0]),
    .done(done[0]), .illegal(illegal[0])
  );

  alu_op_issuer #(.BITS(32), .SIG_COUNT(12), .SETTLE(3)) u_s3 (
    .clk(clk), .clr(clr[1]), .op_valid(op_valid[1]),
    .op_ready(op_ready[1]), .opcode(opcode), .a_in(a_in),
    .b_in(b_in), .ctrl_signal(ctrl[1]), .X(X[1]), .Y(Y[1]),
    .OpResult(opres), .HI(HI[1]), .LO(LO[1]), .Z(Z[1]),
    .done(done[1]), .illegal(illegal[1])
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input int d, input string tag);
    chk({tag, "_X"},  64'(X[d]),  64'(exp_X[d]));
    chk({tag, "_Y"},  64'(Y[d]),  64'(exp_Y[d]));
    chk({tag, "_HI"}, 64'(HI[d]), 64'(exp_HI[d]));
    chk({tag, "_LO"}, 64'(LO[d]), 64'(exp_LO[d]));
    chk({tag, "_Z"},  64'(Z[d]),  64'(exp_Z[d]));
  endtask

  task automatic model_clear(input int d);
    exp_X[d]  = 0;
    exp_Y[d]  = 0;
    exp_HI[d] = 0;
    exp_LO[d] = 0;
    exp_Z[d]  = 0;
  endtask

  function automatic logic [63:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    int s;
    s = int'(b[4:0]);
    r = 0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: return 64'($signed(a) * $signed(b));
      4'd3: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {a % b, a / b};
      4'd4: r = a >> s;
      4'd5: r = a << s;
      4'd6: r = (a >> s) | (a << (32 - s));
      4'd7: r = (a << s) | (a >> (32 - s));
      4'd8: r = a & b;
      4'd9: r = a | b;
      4'd10: r = -a;
      4'd11: r = ~a;
      default: r = 32'hDEAD_BEEF;
    endcase
    return {32'd0, r};
  endfunction

  // One request on instance d; checks every cycle until IDLE again.
  task automatic run_op(input int d, input logic [3:0] opc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] res);
    int s;
    s = (d == 0) ? 1 : 3;
    chk("pre_ready", 64'(op_ready[d]), 64'd1);
    opcode = opc;
    a_in = a;
    b_in = b;
    opres = res;
    op_valid[d] = 1;
    step();
    op_valid[d] = 0;
    if (opc >= 12) begin
      chk("ill_pulse", 64'(illegal[d]), 64'd1);
      chk("ill_ctrl", 64'(ctrl[d]), 64'd0);
      chk("ill_ready", 64'(op_ready[d]), 64'd1);
      chk("ill_done", 64'(done[d]), 64'd0);
      chk_regs(d, "ill");
      step();
      chk("ill_clear", 64'(illegal[d]), 64'd0);
    end else begin
      exp_X[d] = a;
      exp_Y[d] = b;
      for (int k = 0; k < s; k++) begin
        chk("wait_ctrl", 64'(ctrl[d]), 64'd1 << opc);
        chk("wait_ready", 64'(op_ready[d]), 64'd0);
        chk("wait_done", 64'(done[d]), 64'd0);
        chk_regs(d, "wait");
        step();
      end
      if (opc == 2 || opc == 3) begin
        exp_HI[d] = res[63:32];
        exp_LO[d] = res[31:0];
      end else begin
        exp_Z[d] = res[31:0];
      end
      chk("cap_ctrl", 64'(ctrl[d]), 64'd0);
      chk("cap_done", 64'(done[d]), 64'd1);
      chk("cap_ill", 64'(illegal[d]), 64'd0);
      chk("cap_ready", 64'(op_ready[d]), 64'd0);
      chk_regs(d, "cap");
      step();
      chk("post_done", 64'(done[d]), 64'd0);
      chk("post_ready", 64'(op_ready[d]), 64'd1);
      chk_regs(d, "post");
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("onehot0", 64'($onehot0(ctrl[i])), 64'd1);
        chk("done_ill", 64'(done[i] & illegal[i]), 64'd0);
      end
    end
  end

  initial begin
    int d1, d2, ndone;
    clr[0] = 1;
    clr[1] = 1;
    op_valid[0] = 0;
    op_valid[1] = 0;
    opcode = 0;
    a_in = 0;
    b_in = 0;
    opres = 0;
    model_clear(0);
    model_clear(1);
    step();
    step();
    clr[0] = 0;
    clr[1] = 0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ctrl", 64'(ctrl[i]), 64'd0);
      chk("rst_ready", 64'(op_ready[i]), 64'd1);
      chk("rst_done", 64'(done[i]), 64'd0);
      chk("rst_ill", 64'(illegal[i]), 64'd0);
      chk_regs(i, "rst");
    end
    mon_en = 1;

    run_op(0, 4'd0, 32'd15, 32'd5, 64'd20);
    chk("add_Z", 64'(Z[0]), 64'd20);
    run_op(0, 4'd2, 32'hFFFF_FFF1, 32'd5, 64'hFFFF_FFFF_FFFF_FFB5);
    chk("mul_HI", 64'(HI[0]), 64'hFFFF_FFFF);
    chk("mul_LO", 64'(LO[0]), 64'hFFFF_FFB5);
    chk("mul_Z", 64'(Z[0]), 64'd20);
    run_op(0, 4'd12, 32'd7, 32'd9, 64'd99);

    // Reset mid-WAIT on the SETTLE=3 instance discards the op.
    run_op(1, 4'd5, 32'd3, 32'd1, 64'd6);
    clr[1] = 1;
    step();
    clr[1] = 0;
    model_clear(1);
    opcode = 4'd5;
    a_in = 32'd16;
    b_in = 32'd2;
    opres = 64'd64;
    op_valid[1] = 1;
    step();
    op_valid[1] = 0;
    step();
    clr[1] = 1;
    step();
    clr[1] = 0;
    chk("clr_ctrl", 64'(ctrl[1]), 64'd0);
    chk("clr_Z", 64'(Z[1]), 64'd0);
    chk("clr_ready", 64'(op_ready[1]), 64'd1);
    chk("clr_done", 64'(done[1]), 64'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("clr_nodone", 64'(done[1]), 64'd0);
      chk_regs(1, "clr");
    end

    // Back-to-back with op_valid held: AND then OR.
    d1 = 0;
    d2 = 0;
    ndone = 0;
    opcode = 4'd8;
    a_in = 32'd15;
    b_in = 32'd0;
    opres = 64'd15;
    op_valid[1] = 1;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) opcode = 4'd9;
      if (c >= 1 && c <= 3)
        chk("tp_ctrl_and", 64'(ctrl[1]), 64'h100);
      if (c >= 6 && c <= 8)
        chk("tp_ctrl_or", 64'(ctrl[1]), 64'h200);
      if (c >= 1 && c <= 4)
        chk("tp_busy", 64'(op_ready[1]), 64'd0);
      if (done[1]) begin
        ndone++;
        chk("tp_Z", 64'(Z[1]), 64'd15);
        if (ndone == 1) d1 = c;
        else begin
          d2 = c;
          op_valid[1] = 0;
        end
      end
    end
    op_valid[1] = 0;
    chk("tp_done1", 64'(d1), 64'd4);
    chk("tp_done2", 64'(d2), 64'd9);
    chk("tp_gap", 64'(d2 - d1), 64'd5);
    chk("tp_count", 64'(ndone), 64'd2);
    exp_X[1] = 32'd15;
    exp_Y[1] = 32'd0;
    exp_Z[1] = 32'd15;
    step();
    step();

    for (int n = 0; n < 150; n++) begin
      int d;
      logic [3:0] opc;
      logic [31:0] a, b;
      d = int'($urandom_range(0, 1));
      opc = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      run_op(d, opc, a, b, alu_ref(opc, a, b));
    end

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_issuer.md
ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

Interface
REQ-001 Parameter BITS, default 32, operand width.
REQ-002 Parameter SIG_COUNT, default 12, one-hot ALU control width.
REQ-003 Parameter SETTLE, default 1, legal range 1..15, cycles ALU control is held before the result is captured.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port clr  in  1  reset, synchronous, active-high.
REQ-006 Port op_valid  in  1  request qualifier.
REQ-007 Port op_ready  out  1  block accepts a request this cycle.
REQ-008 Port opcode  in  4  operation index: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 AND, 9 OR, 10 NEG, 11 NOT.
REQ-009 Port a_in  in  BITS  first operand.
REQ-010 Port b_in  in  BITS  second operand.
REQ-011 Port ctrl_signal  out  SIG_COUNT  one-hot ALU control.
REQ-012 Port X  out  BITS  ALU operand X.
REQ-013 Port Y  out  BITS  ALU operand Y.
REQ-014 Port OpResult  in  2*BITS  ALU result.
REQ-015 Port HI  out  BITS  upper result register (MUL/DIV only).
REQ-016 Port LO  out  BITS  lower result register (MUL/DIV only).
REQ-017 Port Z  out  BITS  general result register (all other ops).
REQ-018 Port done  out  1  one-cycle pulse after a capture.
REQ-019 Port illegal  out  1  one-cycle pulse for a rejected opcode.

Function
REQ-020 States SHALL be IDLE, WAIT, DONE; op_ready SHALL be 1 only in IDLE.
REQ-021 Accept = op_valid && op_ready at a rising edge; op_valid SHALL be ignored in WAIT and DONE.
REQ-022 On accepting opcode < SIG_COUNT: latch a_in->X, b_in->Y, set ctrl_signal bit [opcode] only, load 4-bit counter with SETTLE-1, go to WAIT.
REQ-023 On accepting opcode >= SIG_COUNT: illegal=1 for the next cycle, stay IDLE, ctrl_signal, X, Y, HI, LO, Z unchanged.
REQ-024 WAIT: ctrl_signal held; counter decrements each edge; at the edge where counter==0, capture OpResult, clear ctrl_signal to 0, go to DONE.
REQ-025 Capture for MUL/DIV: HI<=OpResult[2*BITS-1:BITS], LO<=OpResult[BITS-1:0]; Z unchanged.
REQ-026 Capture for other ops: Z<=OpResult[BITS-1:0]; HI, LO unchanged.
REQ-027 Timing: accept at edge E; ctrl_signal one-hot for exactly SETTLE cycles; capture at edge E+SETTLE; done=1 in cycle following E+SETTLE only; IDLE (op_ready=1) after edge E+SETTLE+1.
REQ-028 Throughput SHALL be one op per SETTLE+2 cycles with op_valid held high.
REQ-029 X, Y SHALL remain stable from accept until next accept.
REQ-030 done and illegal SHALL never be asserted together.
REQ-031 ctrl_signal SHALL be zero or exactly one-hot in every cycle.

Reset
REQ-032 clr=1 at an edge: state IDLE, ctrl_signal=0, X=Y=HI=LO=Z=0, done=illegal=0, counter=0; op_ready=1 the cycle after.
REQ-033 clr SHALL take priority over accept and capture; clr during WAIT SHALL discard the op with no register write and no done pulse.

Verification
REQ-034 Reset: clr one cycle -> ctrl_signal=0, HI=LO=Z=0, op_ready=1, done=0.
REQ-035 ADD a=15 b=5, SETTLE=1, ALU model returns 20 -> ctrl_signal=12'h001 for 1 cycle, Z=20, done one cycle, HI/LO unchanged.
REQ-036 MUL a=-15 b=5, model returns 64-bit -75 -> ctrl_signal=12'h004, HI=32'hFFFFFFFF, LO=32'hFFFFFFB5, Z unchanged.
REQ-037 opcode=12 -> illegal one cycle, ctrl_signal stays 0, registers unchanged, op_ready stays 1.
REQ-038 SETTLE=3, SHL a=16 b=2, clr asserted in 2nd WAIT cycle -> no capture, Z=0, done never asserted, ctrl_signal=0 after clr edge.
REQ-039 SETTLE=3, op_valid held high with AND then OR (a=15 b=0) -> done pulses 5 cycles apart, Z=15 after each, second op not accepted before op_ready returns.
